// File: rtl/core_pkg.sv
// Shared core definitions: data width, register-address type and the shift
// encodings of the ALU that consumes the register-file operands.
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

endpackage

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports, one write port,
// a debug read port and a count of committed writes.
module reg_file
  import core_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = core_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  reg_addr_t       wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  reg_addr_t       dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     wr_count
);

  // x0 has no storage; address 0 is decoded to a constant zero on every port.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [31:0]     wr_count_q;
  logic            commit;

  assign commit = we && (wr_addr != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else if (commit) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  // Reads see the pre-edge contents; the single-cycle core needs no bypass.
  assign rd1      = (rs1_addr == REG_ZERO) ? '0 : regs[rs1_addr];
  assign rd2      = (rs2_addr == REG_ZERO) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven vectors against a reference
// model with a scoreboard, plus reset, sweep and counter-wrap sequences.
module tb_reg_file;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_addr_t   rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic [31:0] rd1, rd2, wr_data, dbg_data, wr_count;
  logic        we;

  reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1(rd1), .rd2(rd2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, dbg, cnt;
  } exp_t;

  typedef struct {
    logic        we;
    reg_addr_t   wa;
    logic [31:0] wd;
    reg_addr_t   a1, a2, ad;
    logic [31:0] exp_rd1;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] model[32];
  logic [31:0] model_cnt;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] model_rd(reg_addr_t a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  function automatic logic [31:0] shifter(logic [3:0] op, logic [31:0] d, logic [4:0] sh);
    case (op)
      ALU_SLL: return d << sh;
      ALU_SRL: return d >> sh;
      ALU_SRA: return $unsigned($signed(d) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, "_rd1"}, rd1, e.rd1);
    check({name, "_rd2"}, rd2, e.rd2);
    check({name, "_dbg"}, dbg_data, e.dbg);
    check({name, "_cnt"}, wr_count, e.cnt);
  endtask

  // Drive one cycle of inputs at the falling edge, check the pre-edge reads,
  // then advance the model at the rising edge.
  task automatic applyStimulus(input logic w, input reg_addr_t wa, input logic [31:0] wd,
                               input reg_addr_t a1, input reg_addr_t a2, input reg_addr_t ad,
                               input string name);
    exp_t e;
    @(negedge clk);
    we = w; wr_addr = wa; wr_data = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    e.rd1 = model_rd(a1);
    e.rd2 = model_rd(a2);
    e.dbg = model_rd(ad);
    e.cnt = model_cnt;
    sb.push_back(e);
    #1 checkOutput(name);
    @(posedge clk);
    if (rst_n && w && wa != 5'd0) begin
      model[wa] = wd;
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'h0};
    vecs[1] = '{1'b0, 5'd5, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 5'd0, 32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd0, 5'd7, 32'h0};
    vecs[5] = '{1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 5'd7, 32'h11111111};
    vecs[6] = '{1'b0, 5'd7, 32'h33333333, 5'd7, 5'd7, 5'd7, 32'h22222222};
    vecs[7] = '{1'b1, 5'd3, 32'h80000000, 5'd3, 5'd0, 5'd3, 32'h0};
    vecs[8] = '{1'b1, 5'd4, 32'h0000001F, 5'd3, 5'd4, 5'd4, 32'h80000000};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 5'd4, 32'h80000000};

    clearModel();
    rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    #12;
    check("reset_cnt", wr_count, 32'h0);
    rs1_addr = 5'd9; dbg_addr = 5'd9;
    #1;
    check("reset_rd1", rd1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2,
                    vecs[i].ad, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table_rd1", i), rd1, vecs[i].exp_rd1);
    end

    // Operand feed into a shift: x3 >> x4[4:0]
    #1;
    check("shamt", {27'd0, rd2[4:0]}, 32'd31);
    check("srl_result", shifter(ALU_SRL, rd1, rd2[4:0]), 32'h00000001);
    check("cnt_after_table", wr_count, 32'd5);

    // Mid-cycle asynchronous reset, with a write presented while held
    @(negedge clk);
    we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd7; dbg_addr = 5'd3;
    #1 check("pre_reset_x5", rd1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);
    check("async_rst_dbg", dbg_data, 32'h0);
    check("async_rst_cnt", wr_count, 32'h0);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hAAAA5555;
    @(posedge clk);
    #1 check("rst_write_cnt", wr_count, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    clearModel();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 5'd9, "post_rst");

    // Full sweep of x1..x31
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b1, 5'(a), 32'(a) * 32'h01010101, 5'(a), 5'(a), 5'(a), $sformatf("sw_w%0d", a));
    end
    for (int a = 1; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 5'(a), $sformatf("sw_r%0d", a));
    end
    #1 check("sweep_cnt", wr_count, 32'd31);
    check("sweep_x31", dbg_data, 32'h1F1F1F1F);

    // Counter wrap: preload the counter, then commit one write
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1 release dut.wr_count_q;
    model_cnt = 32'hFFFFFFFF;
    #1 check("preload_cnt", wr_count, 32'hFFFFFFFF);
    applyStimulus(1'b1, 5'd2, 32'h12345678, 5'd2, 5'd0, 5'd2, "wrap_write");
    #1 check("wrap_cnt", wr_count, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd2, 5'd2, "wrap_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
